rhythm_game_ctrl: RTL and testbench

Sequencer for the rhythm-key game. It plays the target rhythm on a cue LED and then opens a listening window. In that window it times each player key press, classifies it short or long and compares it against the programmed pattern. It reports win or lose and keeps a consecutive-win score. It sits between the board push-button, the start button and the game LEDs.

---
 rtl/rhythm_pkg.sv | 27 ++
 rtl/press_timer.sv | 60 ++++++
 rtl/rhythm_game_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rhythm_game_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-key game sequencer.
// Latency: none (declarations and a pure helper function only).
// Backpressure: not applicable.
package rhythm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_LISTEN,
        ST_WIN,
        ST_LOSE
    } state_t;

    // Pattern element encoding: one bit per element.
    localparam logic LONG  = 1'b1;
    localparam logic SHORT = 1'b0;

    // Width of the press-duration counter and of the phase/timeout timer.
    localparam int TIMER_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
        return (&v) ? v : v + {{(TIMER_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/press_timer.sv
// Synchronizes the player key, measures each press and classifies it short/long on release.
// Latency: rel_valid asserts 2 cycles after the raw key rises (synchronizer depth).
// Backpressure: none; rel_valid is a one-cycle pulse the consumer may ignore.
module press_timer
    import rhythm_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_up,
    output logic rel_valid,
    output logic rel_long
);

    localparam logic [TIMER_W-1:0] LONG_TH = TIMER_W'(LONG_CYCLES);

    logic               sync1_q;
    logic               sync2_q;
    logic               prev_q;
    logic [TIMER_W-1:0] dur_q;
    logic [TIMER_W-1:0] dur_d;

    // Two-flop synchronizer plus a copy of the last synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Count cycles held low (saturating); any released cycle, including the release edge, clears it.
    always_comb begin
        dur_d = '0;
        if (!sync2_q) begin
            dur_d = sat_inc(dur_q);
        end
    end

    // Duration register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dur_q <= '0;
        end else begin
            dur_q <= dur_d;
        end
    end

    // dur_q still holds the full press length during the release-edge cycle.
    assign key_up    = sync2_q;
    assign rel_valid = sync2_q & ~prev_q;
    assign rel_long  = rel_valid & (dur_q >= LONG_TH);

endmodule

// File: rtl/rhythm_game_ctrl.sv
// Rhythm-key game sequencer: plays the pattern on the cue LED, then times and checks player presses.
// Latency: start -> cue on the next edge; raw key release -> win/lose LED 3 cycles later.
// Backpressure: none; start outside IDLE and releases outside LISTEN are dropped.
module rhythm_game_ctrl
    import rhythm_pkg::*;
#(
    parameter int unsigned PATTERN_LEN = 4,
    parameter logic [7:0]  PATTERN     = 8'b0000_0100,
    parameter int unsigned LONG_CYCLES = 25_000_000,
    parameter int unsigned SHORT_SHOW  = 12_500_000,
    parameter int unsigned LONG_SHOW   = 50_000_000,
    parameter int unsigned GAP         = 12_500_000,
    parameter int unsigned TIMEOUT     = 250_000_000,
    parameter int unsigned RESULT_HOLD = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       start,
    output logic       led_cue,
    output logic       led_ini,
    output logic       led_g,
    output logic       led_r,
    output logic       busy,
    output logic [3:0] score
);

    // Timers count 0..limit-1, so each compare value is one less than the duration.
    localparam logic [TIMER_W-1:0] SHORT_LIM = TIMER_W'(SHORT_SHOW - 1);
    localparam logic [TIMER_W-1:0] LONG_LIM  = TIMER_W'(LONG_SHOW - 1);
    localparam logic [TIMER_W-1:0] GAP_LIM   = TIMER_W'(GAP - 1);
    localparam logic [TIMER_W-1:0] TO_LIM    = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HOLD_LIM  = TIMER_W'(RESULT_HOLD - 1);
    localparam logic [2:0]         LAST_IDX  = 3'(PATTERN_LEN - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         score_q, score_d;
    logic               armed_q, armed_d;

    logic               key_up;
    logic               rel_valid;
    logic               rel_long;
    logic               cur_elem;
    logic [TIMER_W-1:0] show_lim;

    press_timer #(
        .LONG_CYCLES(LONG_CYCLES)
    ) u_press_timer (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .key_up   (key_up),
        .rel_valid(rel_valid),
        .rel_long (rel_long)
    );

    assign cur_elem = PATTERN[idx_q];
    assign show_lim = (cur_elem == LONG) ? LONG_LIM : SHORT_LIM;
    assign score    = score_q;

    // State, index, shared phase/timeout timer, score and the LISTEN arming flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            score_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            score_q <= score_d;
            armed_q <= armed_d;
        end
    end

    // Next-state logic and LED decode from the registered state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q + {{(TIMER_W-1){1'b0}}, 1'b1};
        score_d = score_q;
        armed_d = 1'b0;
        led_cue = 1'b0;
        led_ini = 1'b0;
        led_g   = 1'b0;
        led_r   = 1'b0;
        busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (start) begin
                    state_d = ST_SHOW_ON;
                    idx_d   = '0;
                end
            end

            ST_SHOW_ON: begin
                led_cue = 1'b1;
                if (timer_q == show_lim) begin
                    state_d = ST_SHOW_OFF;
                    timer_d = '0;
                end
            end

            ST_SHOW_OFF: begin
                if (timer_q == GAP_LIM) begin
                    timer_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_LISTEN;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SHOW_ON;
                    end
                end
            end

            ST_LISTEN: begin
                led_ini = 1'b1;
                // A key already down on entry must be seen released once before presses count.
                armed_d = armed_q | key_up;
                // The release check comes first so it beats a coincident timeout.
                if (rel_valid && armed_q) begin
                    if (rel_long != cur_elem) begin
                        state_d = ST_LOSE;
                        timer_d = '0;
                        score_d = '0;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_WIN;
                        timer_d = '0;
                        score_d = (score_q == 4'd15) ? score_q : score_q + 4'd1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        timer_d = '0;
                    end
                end else if (timer_q == TO_LIM) begin
                    state_d = ST_LOSE;
                    timer_d = '0;
                    score_d = '0;
                end
            end

            ST_WIN: begin
                led_g = 1'b1;
                if (timer_q == HOLD_LIM) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end

            ST_LOSE: begin
                led_r = 1'b1;
                if (timer_q == HOLD_LIM) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rhythm_game_ctrl.sv
// Self-checking bench for rhythm_game_ctrl with short timing parameters.
// Expected behaviour comes from a pattern/score model driven by directed and random press lengths.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_rhythm_game_ctrl;

    localparam int          LEN          = 4;
    localparam logic [7:0]  PAT          = 8'b0000_0100;
    localparam int          LONG_C       = 8;
    localparam int          SHORT_SHOW_C = 3;
    localparam int          LONG_SHOW_C  = 10;
    localparam int          GAP_C        = 2;
    localparam int          TIMEOUT_C    = 50;
    localparam int          HOLD_C       = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       start;
    logic       led_cue, led_ini, led_g, led_r, busy;
    logic [3:0] score;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_score = 0;
    int press_q[$];
    int gap_q[$];

    rhythm_game_ctrl #(
        .PATTERN_LEN(LEN),
        .PATTERN    (PAT),
        .LONG_CYCLES(LONG_C),
        .SHORT_SHOW (SHORT_SHOW_C),
        .LONG_SHOW  (LONG_SHOW_C),
        .GAP        (GAP_C),
        .TIMEOUT    (TIMEOUT_C),
        .RESULT_HOLD(HOLD_C)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .start  (start),
        .led_cue(led_cue),
        .led_ini(led_ini),
        .led_g  (led_g),
        .led_r  (led_r),
        .busy   (busy),
        .score  (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cue"},   led_cue, 0);
        chk({tag, "_ini"},   led_ini, 0);
        chk({tag, "_g"},     led_g,   0);
        chk({tag, "_r"},     led_r,   0);
        chk({tag, "_busy"},  busy,    0);
        chk({tag, "_score"}, score,   0);
    endtask

    // Pulse start for one clock; called on a falling edge while idle.
    task automatic start_round;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_start", busy, 1);
        chk("cue_on_start", led_cue, 1);
    endtask

    // Expected cue waveform built element by element from the pattern bits.
    task automatic check_playback(input int stray_at, input int hold_from);
        int cyc = 0;
        for (int i = 0; i < LEN; i++) begin
            int show;
            show = PAT[i] ? LONG_SHOW_C : SHORT_SHOW_C;
            for (int c = 0; c < show + GAP_C; c++) begin
                chk("playback_cue", led_cue, (c < show) ? 1 : 0);
                chk("playback_ini", led_ini, 0);
                start = (cyc == stray_at);
                if (hold_from >= 0 && cyc >= hold_from) key = 1'b0;
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("listen_ini", led_ini, 1);
        chk("listen_cue", led_cue, 0);
    endtask

    // Result LED must hold for the full hold time, then everything returns to idle.
    task automatic check_result(input bit win);
        exp_score = win ? ((exp_score == 15) ? 15 : exp_score + 1) : 0;
        for (int c = 0; c < HOLD_C; c++) begin
            if (win) begin
                chk("win_led_g", led_g, 1);
                chk("win_led_r", led_r, 0);
            end else begin
                chk("lose_led_r", led_r, 1);
                chk("lose_led_g", led_g, 0);
            end
            chk("result_ini", led_ini, 0);
            chk("result_busy", busy, 1);
            chk("result_score", score, exp_score);
            @(negedge clk);
        end
        chk("idle_led_g", led_g, 0);
        chk("idle_led_r", led_r, 0);
        chk("idle_busy", busy, 0);
        chk("idle_score", score, exp_score);
    endtask

    // Plays press_q/gap_q and predicts the outcome from the classification threshold and pattern.
    task automatic run_presses;
        bit done = 1'b0;
        for (int k = 0; k < press_q.size() && !done; k++) begin
            bit is_long;
            repeat (gap_q[k]) @(negedge clk);
            key = 1'b0;
            repeat (press_q[k]) @(negedge clk);
            key = 1'b1;
            is_long = (press_q[k] >= LONG_C);
            @(negedge clk);
            @(negedge clk);
            chk("no_early_g", led_g, 0);
            chk("no_early_r", led_r, 0);
            chk("sync_wait_ini", led_ini, 1);
            @(negedge clk);
            if (is_long != PAT[k]) begin
                done = 1'b1;
                check_result(1'b0);
            end else if (k == LEN - 1) begin
                done = 1'b1;
                check_result(1'b1);
            end else begin
                chk("next_elem_ini", led_ini, 1);
            end
        end
    endtask

    task automatic load_correct;
        press_q.delete();
        gap_q.delete();
        for (int k = 0; k < LEN; k++) begin
            press_q.push_back(PAT[k] ? 12 : 3);
            gap_q.push_back(2);
        end
    endtask

    initial begin
        rst   = 1'b0;
        key   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        // Round 1: playback with a stray start mid-sequence, then correct presses.
        start_round();
        check_playback(5, -1);
        load_correct();
        run_presses();

        // Round 2: repeat, score goes to 2.
        start_round();
        check_playback(-1, -1);
        run_presses();

        // Round 3: key held across LISTEN entry; its release must not count.
        start_round();
        check_playback(-1, 20);
        repeat (5) @(negedge clk);
        chk("held_ini", led_ini, 1);
        key = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_release_ini", led_ini, 1);
        chk("held_release_r", led_r, 0);
        chk("held_release_g", led_g, 0);
        load_correct();
        run_presses();

        // Round 4: asynchronous reset in the middle of LISTEN with score 3.
        chk("pre_reset_score", score, 3);
        start_round();
        check_playback(-1, -1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b1;
        exp_score = 0;
        @(negedge clk);

        // Win, then a wrong third element clears the score.
        start_round();
        check_playback(-1, -1);
        run_presses();
        start_round();
        check_playback(-1, -1);
        press_q = '{3, 3, 5};
        gap_q   = '{2, 2, 2};
        run_presses();

        // Win, then a timeout with no presses.
        start_round();
        check_playback(-1, -1);
        load_correct();
        run_presses();
        start_round();
        check_playback(-1, -1);
        for (int c = 0; c < TIMEOUT_C; c++) begin
            chk("timeout_listen", led_ini, 1);
            chk("timeout_no_r", led_r, 0);
            @(negedge clk);
        end
        check_result(1'b0);

        // Sixteen consecutive wins: score saturates at 15.
        load_correct();
        for (int r = 0; r < 16; r++) begin
            start_round();
            check_playback(-1, -1);
            run_presses();
        end
        chk("saturated_score", score, 15);

        // Random rounds, mostly well-formed with occasional wrong lengths.
        for (int r = 0; r < 20; r++) begin
            press_q.delete();
            gap_q.delete();
            for (int k = 0; k < LEN; k++) begin
                int d;
                if ($urandom_range(0, 9) < 8)
                    d = PAT[k] ? int'($urandom_range(8, 16)) : int'($urandom_range(1, 7));
                else
                    d = int'($urandom_range(1, 16));
                press_q.push_back(d);
                gap_q.push_back(int'($urandom_range(1, 4)));
            end
            start_round();
            check_playback(-1, -1);
            run_presses();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
